spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 186 ++++++++++++++++++
 tb/tb_spi_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master that sends a 17-bit command frame and checks a fixed response header.
// Captures a read byte and reports a header error when each frame completes.
module spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       hdr_err,
    output logic       spi_clk,
    output logic       spi_cs,
    output logic       spi_sdi,
    input  logic       spi_sdo
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] HALF_LAST   = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT    = 5'd16;
    localparam logic [6:0] HDR_PATTERN = 7'b0100100;

    state_t      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic        hdr_bad_q, hdr_bad_d;
    logic        rw_q, rw_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        hdr_err_q, hdr_err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        sdi_q, sdi_d;

    logic        half_done;
    logic        accept;
    logic [2:0]  hdr_idx;

    assign half_done = (hcnt_q == 8'd0);
    // The final GAP cycle doubles as the first cycle a new frame may be accepted.
    assign accept    = start && ((state_q == IDLE) || ((state_q == GAP) && half_done));
    assign hdr_idx   = 3'(5'd8 - bit_q);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        hdr_bad_d = hdr_bad_q;
        rw_d      = rw_q;
        rdata_d   = rdata_q;
        hdr_err_d = hdr_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cs_d      = cs_q;
        sclk_d    = sclk_q;
        sdi_d     = sdi_q;

        case (state_q)
            IDLE: begin
            end
            SHIFT: begin
                if (!half_done) begin
                    hcnt_d = hcnt_q - 8'd1;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    hcnt_d = HALF_LAST;
                    if ((bit_q >= 5'd2) && (bit_q <= 5'd8)) begin
                        if (spi_sdo != HDR_PATTERN[hdr_idx]) begin
                            hdr_bad_d = 1'b1;
                        end
                    end else if (bit_q >= 5'd9) begin
                        rx_d = {rx_q[6:0], spi_sdo};
                    end
                end else if (bit_q == LAST_BIT) begin
                    state_d   = HOLD;
                    sclk_d    = 1'b0;
                    cs_d      = 1'b1;
                    sdi_d     = 1'b0;
                    done_d    = 1'b1;
                    hdr_err_d = hdr_bad_q;
                    hcnt_d    = HALF_LAST;
                    if (rw_q) begin
                        rdata_d = rx_q;
                    end
                end else begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 5'd1;
                    sdi_d  = tx_q[15];
                    tx_d   = {tx_q[14:0], 1'b0};
                    hcnt_d = HALF_LAST;
                end
            end
            HOLD: begin
                if (!half_done) begin
                    hcnt_d = hcnt_q - 8'd1;
                end else begin
                    state_d = GAP;
                    busy_d  = 1'b0;
                    hcnt_d  = HALF_LAST;
                end
            end
            GAP: begin
                if (!half_done) begin
                    hcnt_d = hcnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d   = SHIFT;
            hcnt_d    = HALF_LAST;
            bit_d     = 5'd0;
            tx_d      = {rw, addr, 1'b0, (rw ? 8'h00 : wdata), 3'b000};
            rx_d      = 8'h00;
            hdr_bad_d = 1'b0;
            rw_d      = rw;
            busy_d    = 1'b1;
            cs_d      = 1'b0;
            sclk_d    = 1'b0;
            sdi_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hcnt_q    <= 8'd0;
            bit_q     <= 5'd0;
            tx_q      <= 16'h0000;
            rx_q      <= 8'h00;
            hdr_bad_q <= 1'b0;
            rw_q      <= 1'b0;
            rdata_q   <= 8'h00;
            hdr_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            sdi_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            hdr_bad_q <= hdr_bad_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            hdr_err_q <= hdr_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            sdi_q     <= sdi_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign hdr_err = hdr_err_q;
    assign spi_clk = sclk_q;
    assign spi_cs  = cs_q;
    assign spi_sdi = sdi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: directed and random frames on CLK_DIV=2 and CLK_DIV=1 instances,
// checked against frame-level expectations built from the command and slave response.
module tb_spi_master;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       spi_sdo;

    logic       busy_a, done_a, hdr_err_a, sclk_a, cs_a, sdi_a;
    logic [7:0] rdata_a;
    logic       busy_b, done_b, hdr_err_b, sclk_b, cs_b, sdi_b;
    logic [7:0] rdata_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] rd_m [2];
    logic       hd_m [2];

    spi_master #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_a), .done(done_a), .rdata(rdata_a), .hdr_err(hdr_err_a),
        .spi_clk(sclk_a), .spi_cs(cs_a), .spi_sdi(sdi_a), .spi_sdo(spi_sdo)
    );

    spi_master #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_b), .done(done_b), .rdata(rdata_b), .hdr_err(hdr_err_b),
        .spi_clk(sclk_b), .spi_cs(cs_b), .spi_sdi(sdi_b), .spi_sdo(spi_sdo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame on instance sel (0: CLK_DIV=2, 1: CLK_DIV=1). resp[b] is what the
    // slave returns for bit b. pulse_k / rst_k inject a start pulse or reset at cycle T0+k.
    task automatic run_frame(input bit sel, input bit rw_i, input logic [2:0] a_i,
                             input logic [7:0] wd_i, input logic [0:16] resp,
                             input int pulse_k, input int rst_k);
        int          h;
        int          n;
        int          nbits;
        int          cs_low;
        int          cs_first;
        int          cs_falls;
        int          done_cnt;
        int          done_k;
        logic        prev_clk;
        logic        prev_cs;
        logic        o_cs, o_clk, o_sdi, o_done, o_busy, o_hdr;
        logic [7:0]  o_rdata;
        logic [0:16] exp_bits;
        logic [0:16] got;
        logic [7:0]  exp_rd;
        logic        exp_hd;
        logic [7:0]  old_rd;

        h        = sel ? 1 : 2;
        n        = 36 * h + 6;
        nbits    = 0;
        cs_low   = 0;
        cs_first = -1;
        cs_falls = 0;
        done_cnt = 0;
        done_k   = -1;
        prev_clk = 1'b0;
        prev_cs  = 1'b1;
        got      = '0;
        exp_bits = {1'b1, rw_i, a_i, 1'b0, (rw_i ? 8'h00 : wd_i), 3'b000};
        old_rd   = rd_m[sel];
        exp_rd   = rw_i ? resp[9:16] : rd_m[sel];
        exp_hd   = (resp[2:8] != 7'b0100100);

        @(negedge clk);
        rw    = rw_i;
        addr  = a_i;
        wdata = wd_i;
        if (sel) start_b = 1'b1; else start_a = 1'b1;

        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start_a = 1'b0;
                start_b = 1'b0;
                rw      = 1'($urandom);
                addr    = 3'($urandom);
                wdata   = 8'($urandom);
            end
            if (pulse_k != 0 && k == pulse_k) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            if (pulse_k != 0 && k == pulse_k + 1) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (rst_k != 0 && k == rst_k) rst = 1'b1;

            o_cs    = sel ? cs_b      : cs_a;
            o_clk   = sel ? sclk_b    : sclk_a;
            o_sdi   = sel ? sdi_b     : sdi_a;
            o_done  = sel ? done_b    : done_a;
            o_busy  = sel ? busy_b    : busy_a;
            o_hdr   = sel ? hdr_err_b : hdr_err_a;
            o_rdata = sel ? rdata_b   : rdata_a;

            if (rst_k != 0 && k == rst_k + 1) begin
                chk("rst_mid_cs", 32'(o_cs), 32'd1);
                chk("rst_mid_clk", 32'(o_clk), 32'd0);
                chk("rst_mid_busy", 32'(o_busy), 32'd0);
                chk("rst_mid_done", 32'(o_done), 32'd0);
                chk("rst_mid_rdata", 32'(o_rdata), 32'd0);
                chk("rst_mid_hdr", 32'(o_hdr), 32'd0);
                rst = 1'b0;
            end

            if (!o_cs) begin
                cs_low++;
                if (cs_first < 0) cs_first = k;
            end
            if (prev_cs && !o_cs) cs_falls++;
            if (o_clk && !prev_clk) begin
                if (nbits < 17) got[nbits] = o_sdi;
                nbits++;
            end
            if (o_done) begin
                done_cnt++;
                done_k = k;
                chk("done_rdata", 32'(o_rdata), 32'(exp_rd));
                chk("done_hdr_err", 32'(o_hdr), 32'(exp_hd));
            end
            if (rst_k == 0 && k == 34 * h) chk("rdata_before_done", 32'(o_rdata), 32'(old_rd));
            if (rst_k == 0 && k == 35 * h) chk("busy_last", 32'(o_busy), 32'd1);
            if (rst_k == 0 && k == 35 * h + 1) chk("busy_clear", 32'(o_busy), 32'd0);
            if (!o_clk) spi_sdo = resp[(nbits < 17) ? nbits : 0];
            prev_clk = o_clk;
            prev_cs  = o_cs;
        end

        if (rst_k == 0) begin
            chk("sdi_bits", 32'(got), 32'(exp_bits));
            chk("bit_count", 32'(nbits), 32'd17);
            chk("cs_low_cycles", 32'(cs_low), 32'(34 * h));
            chk("cs_first", 32'(cs_first), 32'd1);
            chk("cs_falls", 32'(cs_falls), 32'd1);
            chk("done_count", 32'(done_cnt), 32'd1);
            chk("done_cycle", 32'(done_k), 32'(34 * h + 1));
            rd_m[sel] = exp_rd;
            hd_m[sel] = exp_hd;
        end else begin
            chk("rst_no_done", 32'(done_cnt), 32'd0);
            rd_m[sel] = 8'h00;
            hd_m[sel] = 1'b0;
        end
    endtask

    function automatic logic [0:16] clean_resp(input logic [7:0] data);
        logic [0:16] r;
        r       = 17'($urandom);
        r[2:8]  = 7'b0100100;
        r[9:16] = data;
        return r;
    endfunction

    initial begin
        logic [0:16] resp;
        int          d1, d2, gap;

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        rw      = 1'b0;
        addr    = 3'd0;
        wdata   = 8'h00;
        spi_sdo = 1'b0;
        rd_m[0] = 8'h00; rd_m[1] = 8'h00;
        hd_m[0] = 1'b0;  hd_m[1] = 1'b0;
        start_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_cs", 32'(cs_a), 32'd1);
        chk("reset_clk", 32'(sclk_a), 32'd0);
        chk("reset_sdi", 32'(sdi_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);
        chk("reset_rdata", 32'(rdata_a), 32'd0);
        chk("reset_hdr", 32'(hdr_err_a), 32'd0);
        chk("reset_cs_b", 32'(cs_b), 32'd1);
        start_a = 1'b0;
        rst     = 1'b0;
        repeat (2) @(negedge clk);

        // write 0xA5 to register 2
        run_frame(0, 1'b0, 3'b010, 8'hA5, clean_resp(8'h00), 0, 0);
        // read register 5, slave returns 0x3C
        run_frame(0, 1'b1, 3'b101, 8'hFF, clean_resp(8'h3C), 0, 0);
        // corrupt header bit 4, then a clean frame clears the flag
        resp    = clean_resp(8'h5A);
        resp[4] = 1'b1;
        run_frame(0, 1'b1, 3'b001, 8'h00, resp, 0, 0);
        run_frame(0, 1'b0, 3'b111, 8'h0F, clean_resp(8'h00), 0, 0);
        // start pulse mid-frame must be ignored
        run_frame(0, 1'b0, 3'b011, 8'hC3, clean_resp(8'h00), 10, 0);

        for (int i = 0; i < 6; i++) begin
            resp = clean_resp(8'($urandom));
            if ($urandom_range(0, 3) == 0) resp[2 + $urandom_range(0, 6)] ^= 1'b1;
            run_frame(0, 1'($urandom), 3'($urandom), 8'($urandom), resp, 0, 0);
        end

        // held start: back-to-back writes with slave driving 0 (header mismatch)
        @(negedge clk);
        spi_sdo = 1'b0;
        rw      = 1'b0;
        addr    = 3'd4;
        wdata   = 8'h81;
        start_a = 1'b1;
        d1  = -1;
        d2  = -1;
        gap = 0;
        for (int k = 1; k <= 400 && d2 < 0; k++) begin
            @(negedge clk);
            if (done_a) begin
                if (d1 < 0) d1 = k; else d2 = k;
            end
            if (d1 >= 0 && d2 < 0 && cs_a) gap++;
        end
        start_a = 1'b0;
        chk("held_done_spacing", 32'(d2 - d1), 32'd72);
        chk("held_cs_gap_ok", 32'(gap >= 2), 32'd1);
        chk("held_hdr_err", 32'(hdr_err_a), 32'd1);
        chk("held_rdata", 32'(rdata_a), 32'(rd_m[0]));
        hd_m[0] = 1'b1;
        repeat (10) @(negedge clk);

        // read then reset at T0+30
        run_frame(0, 1'b1, 3'b110, 8'h00, clean_resp(8'hE7), 0, 0);
        run_frame(0, 1'b1, 3'b010, 8'h00, clean_resp(8'h99), 0, 30);
        repeat (4) @(negedge clk);
        run_frame(0, 1'b0, 3'b010, 8'hA5, clean_resp(8'h00), 0, 0);

        // CLK_DIV=1 instance
        run_frame(1, 1'b0, 3'b010, 8'hA5, clean_resp(8'h00), 0, 0);
        for (int i = 0; i < 3; i++) begin
            resp = clean_resp(8'($urandom));
            if ($urandom_range(0, 2) == 0) resp[2 + $urandom_range(0, 6)] ^= 1'b1;
            run_frame(1, 1'($urandom), 3'($urandom), 8'($urandom), resp, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
